// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback pipeline has priority, and one
// MDU result is buffered. A starvation limit stalls the pipeline to force the MDU result through.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_wb_enable,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  // state  | meaning
  // EMPTY  | hold_valid=0, the port belongs to the pipeline
  // HELD   | hold_valid=1, starve_cnt<limit, the pipeline still wins
  // FORCE  | hold_valid=1, starve_cnt==limit, the hold wins and the pipeline stalls
  localparam logic [3:0] LIMIT_CNT = 4'(STARVE_LIMIT);

  logic        hold_valid;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;
  logic [3:0]  starve_cnt;

  logic pipe_eff;
  logic hold_zero;
  logic force_hold;
  logic hold_gnt;
  logic pipe_gnt;
  logic capture;

  always_comb begin
    pipe_eff   = pipe_wb_enable && (pipe_rd != 5'd0);
    // A held x0 result is dropped without using the port, so the pipeline keeps it.
    hold_zero  = hold_valid && (hold_rd == 5'd0);
    force_hold = hold_valid && !hold_zero && (starve_cnt == LIMIT_CNT);
    hold_gnt   = hold_valid && !hold_zero && (force_hold || !pipe_eff);
    pipe_gnt   = pipe_eff && !hold_gnt;
    pipe_stall = force_hold && pipe_eff;
    mdu_ready  = !hold_valid;
    capture    = mdu_valid && !hold_valid;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_rd    <= 5'd0;
      hold_data  <= 32'd0;
      starve_cnt <= 4'd0;
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_data    <= 32'd0;
    end else begin
      rf_we <= hold_gnt || pipe_gnt;
      if (hold_gnt) begin
        rf_rd   <= hold_rd;
        rf_data <= hold_data;
      end else if (pipe_gnt) begin
        rf_rd   <= pipe_rd;
        rf_data <= pipe_data;
      end

      if (capture) begin
        hold_valid <= 1'b1;
        hold_rd    <= mdu_rd;
        hold_data  <= mdu_data;
        starve_cnt <= 4'd0;
      end else if (hold_gnt || hold_zero) begin
        hold_valid <= 1'b0;
        starve_cnt <= 4'd0;
      end else if (hold_valid && pipe_gnt && (starve_cnt != LIMIT_CNT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order writeback stage and the long-latency multiply/divide unit (MDU). Sits between the writeback stage, the MDU result interface and the register file. Buffers one MDU result and gives the pipeline priority. A starvation limit forces the buffered MDU result through by stalling the writeback stage.

## Interface
- STARVE_LIMIT, 4, consecutive cycles a held MDU result may lose to the pipeline before it is forced (legal range 1..15)
- clock  in  1  system clock; one clock domain, all state on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low (asserted when 0)
- pipe_wb_enable  in  1  writeback stage requests a register write
- pipe_rd  in  5  writeback destination register
- pipe_data  in  32  writeback data
- pipe_stall  out  1  writeback request not taken this cycle; upstream holds pipe_* stable
- mdu_valid  in  1  MDU result available
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result data
- mdu_ready  out  1  arbiter accepts MDU result this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_data  out  32  register-file write data (registered)

## Operation
- Pipe request is effective only if pipe_wb_enable=1 and pipe_rd!=0. Writes to x0 are never issued and never stall.
- Hold register: hold_valid, hold_rd, hold_data. mdu_ready = !hold_valid. Transfer when mdu_valid && mdu_ready; captured at that edge.
- A held result with hold_rd=0 is discarded on the next cycle without using the port. It does not increment starve_cnt.
- starve_cnt: width 4, saturates at STARVE_LIMIT.
- States:
  - EMPTY: hold_valid=0.
  - HELD: hold_valid=1 and starve_cnt<STARVE_LIMIT.
  - FORCE: hold_valid=1 and starve_cnt==STARVE_LIMIT.
- Grant, evaluated combinationally each cycle:
  - EMPTY: pipe granted if effective.
  - HELD: pipe granted if effective, otherwise hold granted. starve_cnt++ when pipe wins.
  - FORCE: hold granted. pipe_stall=1 if pipe request effective.
- pipe_stall=0 in all other cases.
- Hold grant clears hold_valid and starve_cnt → EMPTY. No same-cycle refill, because mdu_ready was 0 that cycle.
- Granted entry drives rf_we=1, rf_rd, rf_data at the next edge. Otherwise rf_we=0 and rf_rd/rf_data hold their last value.
- Ordering: writes occur in grant order. Same-rd ordering between the MDU and the pipeline is the scoreboard's responsibility, not this block's.

## Timing
- Reset (async assert, sync deassert by the system): hold_valid=0, starve_cnt=0, rf_we=0, rf_rd=0, rf_data=0.
- While reset is asserted: mdu_ready=1 and pipe_stall=0 (combinational from reset state).
- Reset mid-operation discards a held result. No write is issued for it.
- Pipe write latency: 1 cycle (request in cycle N → rf_we=1 in N+1).
- MDU write latency: minimum 2 cycles (accept in N, granted in N+1, rf_we=1 in N+2). Worst case N+2+STARVE_LIMIT.
- pipe_stall is combinational from state and pipe_* inputs. It is asserted for exactly one cycle per forced grant.
- At most one rf write per cycle. The port is never idle while an effective request exists.

## Test plan
- Pipe only: pipe_wb_enable=1, pipe_rd=5, pipe_data=0xDEADBEEF → next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF. pipe_stall stays 0.
- MDU only: mdu_valid=1, rd=7, data=0x12345678 in cycle 0 → mdu_ready=0 in cycle 1, rf_we=1/rf_rd=7 in cycle 2, mdu_ready=1 in cycle 2.
- Starvation, STARVE_LIMIT=4, continuous pipe requests plus one MDU result:
  - Pipe wins 4 cycles after capture.
  - 5th cycle: pipe_stall=1 and the MDU result is written.
  - Following cycle: the stalled pipe request is written, then pipe_stall=0.
- x0 filtering:
  - pipe_rd=0 with pipe_wb_enable=1 → rf_we stays 0 and no stall.
  - MDU rd=0 → hold clears after 1 cycle with no rf_we.
- Back-to-back MDU: mdu_valid held high with two results → second accepted only the cycle after the first is granted. Two writes in order.
- Reset mid-hold: MDU result captured, then reset pulsed low → rf_we=0, mdu_ready=1, and the result is never written after release.
